// File: rtl/morra_match_scoreboard.sv
// Match-level scoreboard for the MorraCinese FSMD: counts games won, drawn games
// and rounds per game, and declares the match winner or a drawn match.
module morra_match_scoreboard #(
  parameter int WIN_TARGET = 3,
  parameter int MAX_GAMES  = 5,
  parameter int SW         = 3,
  parameter int RW         = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    ROUND,
  input  logic [1:0]    GAME,
  input  logic          NEW_MATCH,
  output logic [SW-1:0] SCORE1,
  output logic [SW-1:0] SCORE2,
  output logic [SW-1:0] DRAWS,
  output logic [RW-1:0] ROUND_CNT,
  output logic [RW-1:0] LAST_LEN,
  output logic [1:0]    MATCH,
  output logic          MATCH_DONE
);

  typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;

  state_t          state, state_nx;
  logic [1:0]      game_prev;
  logic [SW-1:0]   s1_nx, s2_nx, dr_nx;
  logic [RW-1:0]   rc_nx, ll_nx, rc_inc;
  logic [1:0]      match_nx;
  logic            done_nx;
  logic            game_end;
  logic [SW+1:0]   games_total;

  function automatic logic [RW-1:0] sat_inc(input logic [RW-1:0] v, input logic inc);
    if (inc && (v != {RW{1'b1}})) return v + RW'(1);
    return v;
  endfunction

  // A GAME value held over several cycles is a single event: only the 00->nonzero edge counts.
  assign game_end = (GAME != 2'b00) && (game_prev == 2'b00);
  assign rc_inc   = sat_inc(ROUND_CNT, ROUND != 2'b00);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      game_prev  <= 2'b00;
      SCORE1     <= '0;
      SCORE2     <= '0;
      DRAWS      <= '0;
      ROUND_CNT  <= '0;
      LAST_LEN   <= '0;
      MATCH      <= 2'b00;
      MATCH_DONE <= 1'b0;
    end else begin
      state      <= state_nx;
      game_prev  <= GAME;
      SCORE1     <= s1_nx;
      SCORE2     <= s2_nx;
      DRAWS      <= dr_nx;
      ROUND_CNT  <= rc_nx;
      LAST_LEN   <= ll_nx;
      MATCH      <= match_nx;
      MATCH_DONE <= done_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    s1_nx       = SCORE1;
    s2_nx       = SCORE2;
    dr_nx       = DRAWS;
    rc_nx       = ROUND_CNT;
    ll_nx       = LAST_LEN;
    match_nx    = MATCH;
    done_nx     = 1'b0;
    games_total = '0;

    if (NEW_MATCH) begin
      // A restart wins over any same-cycle round/game result, which is dropped.
      state_nx = PLAY;
      s1_nx    = '0;
      s2_nx    = '0;
      dr_nx    = '0;
      rc_nx    = '0;
      ll_nx    = '0;
      match_nx = 2'b00;
    end else if (state == PLAY) begin
      if (game_end) begin
        ll_nx = rc_inc;
        rc_nx = '0;
        case (GAME)
          2'b01:   s1_nx = SCORE1 + SW'(1);
          2'b10:   s2_nx = SCORE2 + SW'(1);
          default: dr_nx = DRAWS + SW'(1);
        endcase
        games_total = {2'b00, s1_nx} + {2'b00, s2_nx} + {2'b00, dr_nx};
        if (s1_nx == SW'(WIN_TARGET))
          match_nx = 2'b01;
        else if (s2_nx == SW'(WIN_TARGET))
          match_nx = 2'b10;
        else if (games_total == (SW+2)'(MAX_GAMES))
          match_nx = 2'b11;
        if (match_nx != 2'b00) begin
          state_nx = DONE;
          done_nx  = 1'b1;
        end
      end else begin
        rc_nx = rc_inc;
      end
    end
  end

endmodule

// File: tb/tb_morra_match_scoreboard.sv
// Scoreboard bench for morra_match_scoreboard: directed scenarios plus random traffic,
// checked every cycle against a plain-arithmetic match model.
module tb_morra_match_scoreboard;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] ROUND = 2'b00;
  logic [1:0] GAME = 2'b00;
  logic       NEW_MATCH = 1'b0;
  logic [2:0] SCORE1, SCORE2, DRAWS;
  logic [3:0] ROUND_CNT, LAST_LEN;
  logic [1:0] MATCH;
  logic       MATCH_DONE;

  morra_match_scoreboard #(.WIN_TARGET(3), .MAX_GAMES(5), .SW(3), .RW(4)) dut (
    .clk(clk), .rst_n(rst_n), .ROUND(ROUND), .GAME(GAME), .NEW_MATCH(NEW_MATCH),
    .SCORE1(SCORE1), .SCORE2(SCORE2), .DRAWS(DRAWS), .ROUND_CNT(ROUND_CNT),
    .LAST_LEN(LAST_LEN), .MATCH(MATCH), .MATCH_DONE(MATCH_DONE)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int s1, s2, dr, rc, ll, m, d;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: match bookkeeping in plain integers.
  int m_s1, m_s2, m_dr, m_rc, m_ll, m_match, m_done, m_prev;
  bit m_active;   // counting enabled (a match is running and undecided)

  function automatic void model_step(input bit rn, input bit nm, input int rnd, input int gm);
    bit ge;
    int r;
    if (!rn) begin
      m_s1 = 0; m_s2 = 0; m_dr = 0; m_rc = 0; m_ll = 0;
      m_match = 0; m_done = 0; m_prev = 0; m_active = 0;
      return;
    end
    ge = (gm != 0) && (m_prev == 0);
    m_prev = gm;
    m_done = 0;
    if (nm) begin
      m_s1 = 0; m_s2 = 0; m_dr = 0; m_rc = 0; m_ll = 0; m_match = 0;
      m_active = 1;
    end else if (m_active) begin
      r = m_rc + ((rnd != 0) ? 1 : 0);
      if (r > 15) r = 15;
      if (ge) begin
        m_ll = r;
        m_rc = 0;
        if (gm == 1) m_s1++;
        else if (gm == 2) m_s2++;
        else m_dr++;
        if (m_s1 == 3) m_match = 1;
        else if (m_s2 == 3) m_match = 2;
        else if (m_s1 + m_s2 + m_dr == 5) m_match = 3;
        if (m_match != 0) begin
          m_done = 1;
          m_active = 0;
        end
      end else begin
        m_rc = r;
      end
    end
  endfunction

  task automatic step(input bit rn, input bit nm, input int rnd, input int gm);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rn;
    NEW_MATCH = nm;
    ROUND = rnd[1:0];
    GAME = gm[1:0];
    model_step(rn, nm, rnd, gm);
    e.cyc = cyc + 1;
    e.s1 = m_s1; e.s2 = m_s2; e.dr = m_dr; e.rc = m_rc;
    e.ll = m_ll; e.m = m_match; e.d = m_done;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int exp_v, input int c);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, c, act, exp_v);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare those whose cycle has arrived.
  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      chk("SCORE1", int'(SCORE1), e.s1, e.cyc);
      chk("SCORE2", int'(SCORE2), e.s2, e.cyc);
      chk("DRAWS", int'(DRAWS), e.dr, e.cyc);
      chk("ROUND_CNT", int'(ROUND_CNT), e.rc, e.cyc);
      chk("LAST_LEN", int'(LAST_LEN), e.ll, e.cyc);
      chk("MATCH", int'(MATCH), e.m, e.cyc);
      chk("MATCH_DONE", int'(MATCH_DONE), e.d, e.cyc);
    end
  end

  task automatic game(input int rounds_before, input int g);
    for (int i = 0; i < rounds_before; i++) step(1, 0, 1, 0);
    step(1, 0, 1, g);
    step(1, 0, 0, 0);
  endtask

  initial begin
    int g_hold;
    int wait_cnt;
    // Reset, then activity without NEW_MATCH is ignored.
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 1, 1);
    step(1, 0, 1, 0);
    step(1, 0, 0, 0);

    // P1 sweep, then a late P2 game result is ignored.
    step(1, 1, 0, 0);
    for (int k = 0; k < 3; k++) game(2, 1);
    step(1, 0, 0, 2);
    step(1, 0, 0, 0);

    // Held GAME counts once per rising event.
    step(1, 1, 0, 0);
    for (int k = 0; k < 4; k++) step(1, 0, 1, 2);
    step(1, 0, 0, 0);
    step(1, 0, 0, 2);
    step(1, 0, 0, 2);
    step(1, 0, 0, 0);

    // Drawn match.
    step(1, 1, 0, 0);
    game(1, 1); game(0, 2); game(2, 3); game(1, 1); game(0, 2);
    step(1, 0, 0, 0);

    // NEW_MATCH priority over a same-cycle game end, then round saturation.
    step(1, 1, 0, 1);
    step(1, 0, 0, 0);
    for (int k = 0; k < 20; k++) step(1, 0, 3, 0);
    step(1, 0, 3, 3);
    step(1, 0, 0, 0);

    // Reset mid-match, then a GAME pulse is ignored.
    step(1, 1, 0, 0);
    game(1, 1); game(1, 2); game(1, 1);
    step(0, 0, 0, 0);
    step(1, 0, 1, 1);
    step(1, 0, 0, 0);

    // Random traffic.
    g_hold = 0;
    for (int k = 0; k < 1500; k++) begin
      bit rn, nm;
      rn = ($urandom_range(0, 99) != 0);
      nm = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 2) != 0) begin
        if ($urandom_range(0, 5) == 0) g_hold = $urandom_range(1, 3);
        else g_hold = 0;
      end
      step(rn, nm, $urandom_range(0, 3), g_hold);
    end
    step(1, 0, 0, 0);

    wait_cnt = 0;
    while (q.size() > 0 && wait_cnt < 20) begin
      @(posedge clk);
      wait_cnt++;
    end
    @(posedge clk);
    chk("queue_drained", q.size(), 0, cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
